// File: rtl/posit_pack_pipe.sv
// Two-stage valid/ready posit encoder: regime/exponent/fraction string build in S1,
// round-to-nearest-even, saturation, negation and specials in S2.
module posit_pack_pipe #(
  parameter int BITS = 32,
  parameter int ES   = 3,
  parameter int KW   = $clog2(BITS) + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sign,
  input  logic signed [KW-1:0]          in_k,
  input  logic [((ES > 0) ? ES : 1)-1:0] in_exp,
  input  logic [BITS-1:0]               in_frac,
  input  logic                          in_zero,
  input  logic                          in_nar,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BITS-1:0]               out_posit
);

  localparam int SW  = 2*BITS + ES + 2;
  localparam int WW  = 2*BITS;
  localparam int LW  = SW - WW;
  localparam int SHW = $clog2(BITS);
  localparam logic signed [KW-1:0] K_HI = KW'(BITS-2);
  localparam logic signed [KW-1:0] K_LO = -K_HI;
  localparam logic [KW-1:0]        SH_MAX = KW'(BITS-1);

  function automatic logic [BITS-2:0] round_sat(input logic [WW-1:0] str, input logic stk,
                                                 input logic hi, input logic lo);
    logic [BITS-2:0] mag;
    logic            guard;
    logic            sticky;
    logic [BITS-1:0] sum;
    mag    = str[WW-1 -: BITS-1];
    guard  = str[BITS];
    sticky = stk | (|str[BITS-1:0]);
    sum    = {1'b0, mag} + BITS'(guard & (sticky | mag[0]));
    if (hi || sum[BITS-1]) round_sat = {(BITS-1){1'b1}};
    else if (lo)           round_sat = {{(BITS-2){1'b0}}, 1'b1};
    else                   round_sat = sum[BITS-2:0];
  endfunction

  function automatic logic [BITS-1:0] apply_sign(input logic neg, input logic [BITS-2:0] mag);
    apply_sign = neg ? (~{1'b0, mag} + BITS'(1)) : {1'b0, mag};
  endfunction

  logic [ES+BITS-1:0] w_ef;
  generate
    if (ES > 0) begin : g_exp
      assign w_ef = {in_exp, in_frac};
    end else begin : g_noexp
      logic w_unused_exp;
      assign w_unused_exp = ^in_exp;
      assign w_ef         = in_frac;
    end
  endgenerate

  logic                   w_s1_adv, w_s2_adv;
  logic                   w_sat_hi, w_sat_lo;
  logic [KW-1:0]          w_sh_raw;
  logic [SHW-1:0]         w_sh;
  logic signed [SW-1:0]   w_base;
  logic [SW-1:0]          w_str;
  logic [BITS-1:0]        w_posit;

  logic                   r_vld_p1, r_sign_p1, r_zero_p1, r_nar_p1, r_hi_p1, r_lo_p1, r_stk_p1;
  logic [WW-1:0]          r_str_p1;
  logic                   r_vld_p2;
  logic [BITS-1:0]        r_posit_p2;

  assign w_s2_adv  = !r_vld_p2 || out_ready;
  assign w_s1_adv  = !r_vld_p1 || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_vld_p2;
  assign out_posit = r_posit_p2;

  // The header bit pair plus arithmetic shift right yields the run: 10 fills ones for k>=0,
  // 01 fills zeros for k<0, so the shift amount is k or -k-1.
  assign w_sat_hi = in_k > K_HI;
  assign w_sat_lo = in_k < K_LO;
  assign w_sh_raw = in_k[KW-1] ? ~in_k : in_k;
  assign w_sh     = (w_sh_raw > SH_MAX) ? SHW'(BITS-1) : w_sh_raw[SHW-1:0];
  assign w_base   = {(in_k[KW-1] ? 2'b01 : 2'b10), w_ef, {BITS{1'b0}}};
  assign w_str    = w_base >>> w_sh;

  // Stage 1: clamped, shifted magnitude string and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_vld_p1 <= 1'b0;
    else if (w_s1_adv) r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && w_s1_adv) begin
      r_str_p1  <= w_str[SW-1 -: WW];
      r_stk_p1  <= |w_str[LW-1:0];
      r_sign_p1 <= in_sign;
      r_zero_p1 <= in_zero;
      r_nar_p1  <= in_nar;
      r_hi_p1   <= w_sat_hi;
      r_lo_p1   <= w_sat_lo;
    end
  end

  assign w_posit = r_nar_p1  ? {1'b1, {(BITS-1){1'b0}}} :
                   r_zero_p1 ? '0 :
                   apply_sign(r_sign_p1, round_sat(r_str_p1, r_stk_p1, r_hi_p1, r_lo_p1));

  // Stage 2: rounded, saturated, signed posit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2   <= 1'b0;
      r_posit_p2 <= '0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_posit_p2 <= w_posit;
    end
  end

endmodule

// File: tb/tb_posit_pack_pipe.sv
// Bench for posit_pack_pipe: directed literals, backpressure and reset on an 8/1 instance,
// plus random sweeps on 32/3 and 16/0 instances, all scored against a bit-string model.
module tb_posit_pack_pipe;

  localparam int KA = $clog2(8) + 2;
  localparam int KB = $clog2(32) + 2;
  localparam int KC = $clog2(16) + 2;
  localparam int NSWEEP = 10000;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic        rst_a, iv_a, ir_a, sg_a, zr_a, nr_a, ov_a, ordy_a;
  int          k_a;
  logic [KA-1:0] kp_a;
  logic [0:0]  e_a;
  logic [7:0]  f_a, op_a;

  logic        rst_bc, iv_b, ir_b, sg_b, zr_b, nr_b, ov_b, ordy_b;
  int          k_b;
  logic [KB-1:0] kp_b;
  logic [2:0]  e_b;
  logic [31:0] f_b, op_b;

  logic        iv_c, ir_c, sg_c, zr_c, nr_c, ov_c, ordy_c;
  int          k_c;
  logic [KC-1:0] kp_c;
  logic [0:0]  e_c;
  logic [15:0] f_c, op_c;

  assign kp_a = k_a[KA-1:0];
  assign kp_b = k_b[KB-1:0];
  assign kp_c = k_c[KC-1:0];

  posit_pack_pipe #(.BITS(8), .ES(1)) u_a (
    .clk(clk), .rst_n(rst_a), .in_valid(iv_a), .in_ready(ir_a), .in_sign(sg_a), .in_k(kp_a),
    .in_exp(e_a), .in_frac(f_a), .in_zero(zr_a), .in_nar(nr_a), .out_valid(ov_a),
    .out_ready(ordy_a), .out_posit(op_a));

  posit_pack_pipe #(.BITS(32), .ES(3)) u_b (
    .clk(clk), .rst_n(rst_bc), .in_valid(iv_b), .in_ready(ir_b), .in_sign(sg_b), .in_k(kp_b),
    .in_exp(e_b), .in_frac(f_b), .in_zero(zr_b), .in_nar(nr_b), .out_valid(ov_b),
    .out_ready(ordy_b), .out_posit(op_b));

  posit_pack_pipe #(.BITS(16), .ES(0)) u_c (
    .clk(clk), .rst_n(rst_bc), .in_valid(iv_c), .in_ready(ir_c), .in_sign(sg_c), .in_k(kp_c),
    .in_exp(e_c), .in_frac(f_c), .in_zero(zr_c), .in_nar(nr_c), .out_valid(ov_c),
    .out_ready(ordy_c), .out_posit(op_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: lay out regime, exponent and fraction as a literal bit string, then
  // cut it at BITS-1 bits and round on guard/sticky.
  function automatic logic [63:0] model(input int bits, input int es, input int k,
                                        input logic [63:0] e, input logic [63:0] f,
                                        input logic s, input logic z, input logic n);
    logic [255:0] str;
    int           len;
    logic [63:0]  mag, maxp, res;
    logic         g, st;
    maxp = (64'd1 << (bits-1)) - 64'd1;
    if (n) return 64'd1 << (bits-1);
    if (z) return 64'd0;
    if (k > bits-2)         mag = maxp;
    else if (k < -(bits-2)) mag = 64'd1;
    else begin
      str = '0;
      len = 0;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin str[255-len] = 1'b1; len++; end
        str[255-len] = 1'b0; len++;
      end else begin
        for (int i = 0; i < -k; i++) begin str[255-len] = 1'b0; len++; end
        str[255-len] = 1'b1; len++;
      end
      for (int i = es-1; i >= 0; i--) begin str[255-len] = e[i]; len++; end
      for (int i = bits-1; i >= 0; i--) begin str[255-len] = f[i]; len++; end
      mag = 64'd0;
      for (int i = 0; i < bits-1; i++) mag = {mag[62:0], str[255-i]};
      g  = str[255-(bits-1)];
      st = 1'b0;
      for (int i = bits; i < len; i++) st = st | str[255-i];
      if (g && (st || mag[0])) mag = mag + 64'd1;
      if (mag > maxp) mag = maxp;
    end
    res = s ? (64'd0 - mag) : mag;
    if (bits < 64) res = res & ((64'd1 << bits) - 64'd1);
    return res;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  logic [63:0] q [3][$];
  logic        stall_prev [3];
  logic [63:0] pos_prev [3];

  task automatic scb(input int id, input logic rstn, input logic iv, input logic ir,
                     input logic ov, input logic ordy, input logic [63:0] op, input logic [63:0] mv);
    logic exp_ir;
    if (!rstn) begin
      q[id].delete();
      stall_prev[id] = 1'b0;
      return;
    end
    exp_ir = !(q[id].size() == 2 && !ordy);
    chk(ir == exp_ir, $sformatf("u%0d_in_ready", id), 64'(ir), 64'(exp_ir));
    if (stall_prev[id])
      chk(ov && op == pos_prev[id], $sformatf("u%0d_stall_hold", id), op, pos_prev[id]);
    if (ov) begin
      if (q[id].size() == 0) chk(1'b0, $sformatf("u%0d_unexpected_out", id), op, 64'd0);
      else begin
        chk(op == q[id][0], $sformatf("u%0d_value", id), op, q[id][0]);
        if (ordy) void'(q[id].pop_front());
      end
    end
    stall_prev[id] = ov && !ordy;
    pos_prev[id]   = op;
    if (iv && ir) q[id].push_back(mv);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin stall_prev[i] = 1'b0; pos_prev[i] = '0; end
    forever begin
      @(negedge clk);
      scb(0, rst_a, iv_a, ir_a, ov_a, ordy_a, 64'(op_a),
          model(8, 1, k_a, 64'(e_a), 64'(f_a), sg_a, zr_a, nr_a));
      scb(1, rst_bc, iv_b, ir_b, ov_b, ordy_b, 64'(op_b),
          model(32, 3, k_b, 64'(e_b), 64'(f_b), sg_b, zr_b, nr_b));
      scb(2, rst_bc, iv_c, ir_c, ov_c, ordy_c, 64'(op_c),
          model(16, 0, k_c, 64'(e_c), 64'(f_c), sg_c, zr_c, nr_c));
    end
  end

  task automatic send_a(input bit wait_edge, input int k, input logic e, input logic [7:0] f,
                        input logic s, input logic z, input logic n, input logic [7:0] req,
                        input string nm);
    if (wait_edge) begin @(posedge clk); #1; end
    iv_a = 1'b1; k_a = k; e_a = e; f_a = f; sg_a = s; zr_a = z; nr_a = n; ordy_a = 1'b1;
    @(negedge clk);
    chk(ir_a == 1'b1, {nm, "_ready"}, 64'(ir_a), 64'd1);
    @(posedge clk); #1;
    iv_a = 1'b0;
    @(negedge clk);
    chk(ov_a == 1'b0, {nm, "_early"}, 64'(ov_a), 64'd0);
    @(negedge clk);
    chk(ov_a == 1'b1 && op_a == req, {nm, "_out"}, {ov_a, 55'd0, op_a}, {1'b1, 55'd0, req});
  endtask

  task automatic run_directed();
    int acc, cyc;
    send_a(1,  0, 1'b0, 8'h00, 0, 0, 0, 8'h40, "enc_one");
    send_a(1,  0, 1'b0, 8'h00, 1, 0, 0, 8'hC0, "enc_neg_one");
    send_a(1,  1, 1'b1, 8'h80, 0, 0, 0, 8'h6C, "enc_k1");
    send_a(1, -1, 1'b0, 8'h00, 0, 0, 0, 8'h20, "enc_kneg");
    send_a(1,  0, 1'b0, 8'h88, 0, 0, 0, 8'h48, "rne_tie_even");
    send_a(1,  0, 1'b0, 8'h98, 0, 0, 0, 8'h4A, "rne_tie_odd");
    send_a(1,  0, 1'b0, 8'h89, 0, 0, 0, 8'h49, "rne_above");
    send_a(1,  9, 1'b0, 8'h00, 0, 0, 0, 8'h7F, "sat_hi");
    send_a(1,  9, 1'b0, 8'h00, 1, 0, 0, 8'h81, "sat_hi_neg");
    send_a(1, -9, 1'b0, 8'h00, 0, 0, 0, 8'h01, "sat_lo");
    send_a(1, -6, 1'b1, 8'h00, 0, 0, 0, 8'h02, "minpos_round");
    send_a(1,  6, 1'b1, 8'hFF, 0, 0, 0, 8'h7F, "k_edge_hi");
    send_a(1,  3, 1'b1, 8'h55, 1, 1, 0, 8'h00, "zero");
    send_a(1,  3, 1'b1, 8'h55, 1, 1, 1, 8'h80, "nar");
    send_a(1,  5, 1'b1, 8'hFF, 0, 0, 0, 8'h7F, "max_carry");
    acc = 0; cyc = 0;
    while (acc < 10 && cyc < 500) begin
      @(posedge clk); #1;
      iv_a = 1'($urandom_range(0, 1)); k_a = int'($urandom_range(0, 22)) - 11;
      e_a = 1'($urandom); f_a = 8'($urandom); sg_a = 1'($urandom);
      zr_a = ($urandom_range(0, 7) == 0); nr_a = ($urandom_range(0, 7) == 0);
      ordy_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (iv_a && ir_a) acc++;
      cyc++;
    end
    chk(acc == 10, "bp_accepted", 64'(acc), 64'd10);
    @(posedge clk); #1;
    iv_a = 1'b0; ordy_a = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk(q[0].size() == 0, "bp_drain", 64'(q[0].size()), 64'd0);
    @(posedge clk); #1;
    iv_a = 1'b1; k_a = 2; e_a = 1'b0; f_a = 8'h10; sg_a = 1'b0; zr_a = 1'b0; nr_a = 1'b0;
    @(posedge clk); #1;
    k_a = -2;
    @(posedge clk); #1;
    iv_a = 1'b0;
    chk(ov_a == 1'b1, "rst_inflight", 64'(ov_a), 64'd1);
    #1 rst_a = 1'b0;
    #1 chk(ov_a == 1'b0 && op_a == 8'h00, "rst_clear", {ov_a, 55'd0, op_a}, 64'd0);
    chk(ir_a == 1'b1, "rst_ready", 64'(ir_a), 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_a = 1'b1;
    chk(ir_a == 1'b1 && ov_a == 1'b0, "rst_release", {ir_a, ov_a}, 64'd2);
    send_a(0, 0, 1'b1, 8'h00, 0, 0, 0, 8'h50, "post_rst");
  endtask

  function automatic int pick_k(input int bits);
    case ($urandom_range(0, 5))
      0: return bits - 2;
      1: return -(bits - 2);
      2: return bits - 1;
      3: return -(bits - 1);
      default: return int'($urandom_range(0, 2*bits + 4)) - (bits + 2);
    endcase
  endfunction

  task automatic run_sweep();
    int acc_b, acc_c, cyc;
    acc_b = 0; acc_c = 0; cyc = 0;
    while ((acc_b < NSWEEP || acc_c < NSWEEP) && cyc < 40000) begin
      @(posedge clk); #1;
      iv_b = (acc_b < NSWEEP) && ($urandom_range(0, 3) != 0);
      k_b = pick_k(32); e_b = 3'($urandom); f_b = $urandom; sg_b = 1'($urandom);
      zr_b = ($urandom_range(0, 15) == 0); nr_b = ($urandom_range(0, 15) == 0);
      ordy_b = ($urandom_range(0, 3) != 0);
      iv_c = (acc_c < NSWEEP) && ($urandom_range(0, 3) != 0);
      k_c = pick_k(16); e_c = 1'($urandom); f_c = 16'($urandom); sg_c = 1'($urandom);
      zr_c = ($urandom_range(0, 15) == 0); nr_c = ($urandom_range(0, 15) == 0);
      ordy_c = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (iv_b && ir_b) acc_b++;
      if (iv_c && ir_c) acc_c++;
      cyc++;
    end
    chk(cyc < 40000, "sweep_budget", 64'(cyc), 64'd40000);
    @(posedge clk); #1;
    iv_b = 1'b0; iv_c = 1'b0; ordy_b = 1'b1; ordy_c = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk(q[1].size() == 0, "sweep_drain_b", 64'(q[1].size()), 64'd0);
    chk(q[2].size() == 0, "sweep_drain_c", 64'(q[2].size()), 64'd0);
  endtask

  initial begin
    rst_a = 1'b1; rst_bc = 1'b1;
    iv_a = 0; k_a = 0; e_a = 0; f_a = 0; sg_a = 0; zr_a = 0; nr_a = 0; ordy_a = 1;
    iv_b = 0; k_b = 0; e_b = 0; f_b = 0; sg_b = 0; zr_b = 0; nr_b = 0; ordy_b = 1;
    iv_c = 0; k_c = 0; e_c = 0; f_c = 0; sg_c = 0; zr_c = 0; nr_c = 0; ordy_c = 1;
    #2 rst_a = 1'b0; rst_bc = 1'b0;
    #1;
    chk(ov_a == 1'b0 && op_a == 8'h00, "reset_out_a", {ov_a, 55'd0, op_a}, 64'd0);
    chk(ir_a == 1'b1, "reset_ready_a", 64'(ir_a), 64'd1);
    chk(ov_b == 1'b0 && ov_c == 1'b0, "reset_out_bc", {ov_b, ov_c}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1; rst_bc = 1'b1;
    fork
      run_directed();
      run_sweep();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
